// File: rtl/fp_add_pkg.sv
// Shared types, constants and field helpers for the sequenced float adder.
package fp_add_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMP,
        ST_ALN,
        ST_ADD,
        ST_NRM,
        ST_DONE
    } state_t;

    localparam logic        HIDDEN_BIT = 1'b1;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f_mant(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_lead_one_detect.sv
// Combinational leading-one position encoder for the 25-bit adder sum.
module fp_lead_one_detect (
    input  logic [24:0] vec_in,
    output logic [4:0]  pos_out
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        pos_out = '0;
        for (int i = 0; i < 25; i++) begin
            if (vec_in[i]) pos_out = 5'(i);
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle single-precision adder: compare, align, add, normalize, hand off.
//
// state | meaning
// IDLE  | ready for an operand pair
// CMP   | pick larger operand, register mantissas, exponent, shift, op
// ALN   | right-shift the smaller mantissa
// ADD   | add or subtract mantissas
// NRM   | normalize, detect special cases, pack result
// DONE  | hold result until the consumer takes it
module fp_add_sequencer
    import fp_add_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  overflow_out,
    output logic                  invalid_out,
    output logic                  busy_out,
    output logic [CNT_WIDTH-1:0]  op_count_out
);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d, sub_q, sub_d;
    logic [EXPO_WIDTH-1:0]   exp_q, exp_d, shift_q, shift_d;
    logic [MENT_WIDTH:0]     mant_l_q, mant_l_d, mant_s_q, mant_s_d;
    logic [MENT_WIDTH+1:0]   sum_q, sum_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    ovf_q, ovf_d, inv_q, inv_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic [EXPO_WIDTH-1:0]   exp_a, exp_b;
    logic [MENT_WIDTH:0]     mant_a, mant_b;
    logic [EXPO_WIDTH:0]     exp_diff;
    logic                    a_big;
    logic                    op_inv;
    logic [4:0]              lod_pos, lz;
    logic [EXPO_WIDTH+1:0]   exp_ext;
    logic signed [EXPO_WIDTH+1:0] exp_n;
    logic [MENT_WIDTH-1:0]   mant_n;

    assign exp_a    = f_exp(a_q);
    assign exp_b    = f_exp(b_q);
    assign mant_a   = {(exp_a != '0) ? HIDDEN_BIT : 1'b0, f_mant(a_q)};
    assign mant_b   = {(exp_b != '0) ? HIDDEN_BIT : 1'b0, f_mant(b_q)};
    assign exp_diff = {1'b0, exp_a} - {1'b0, exp_b};
    // Equal exponents fall back to the mantissa; a full tie selects B.
    assign a_big    = !exp_diff[EXPO_WIDTH] && ((exp_diff != '0) || (mant_a > mant_b));
    assign op_inv   = (exp_a == EXP_MAX) || (exp_b == EXP_MAX);
    assign exp_ext  = {2'b00, exp_q};

    fp_lead_one_detect u_lod (
        .vec_in  (sum_q),
        .pos_out (lod_pos)
    );

    // Normalization of the registered sum: carry-out shifts right, otherwise left to the leading one.
    always_comb begin
        lz = 5'(MENT_WIDTH) - lod_pos;
        if (sum_q[MENT_WIDTH+1]) begin
            exp_n  = exp_ext + {{(EXPO_WIDTH+1){1'b0}}, 1'b1};
            mant_n = sum_q[MENT_WIDTH:1];
        end else begin
            exp_n  = exp_ext - {{(EXPO_WIDTH-3){1'b0}}, lz};
            mant_n = sum_q[MENT_WIDTH-1:0] << lz;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid_in) state_d = ST_CMP;
            ST_CMP:  state_d = ST_ALN;
            ST_ALN:  state_d = ST_ADD;
            ST_ADD:  state_d = ST_NRM;
            ST_NRM:  state_d = ST_DONE;
            ST_DONE: if (out_ready_in) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage datapath: each state loads only the registers it owns.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        shift_d  = shift_q;
        mant_l_d = mant_l_q;
        mant_s_d = mant_s_q;
        sum_d    = sum_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_in) begin
                    a_d = floating1_in;
                    b_d = floating2_in;
                end
            end
            ST_CMP: begin
                sign_d   = a_big ? f_sign(a_q) : f_sign(b_q);
                sub_d    = f_sign(a_q) ^ f_sign(b_q);
                exp_d    = a_big ? exp_a : exp_b;
                mant_l_d = a_big ? mant_a : mant_b;
                mant_s_d = a_big ? mant_b : mant_a;
                shift_d  = exp_diff[EXPO_WIDTH] ? (exp_b - exp_a) : exp_diff[EXPO_WIDTH-1:0];
            end
            ST_ALN: begin
                mant_s_d = (shift_q >= EXPO_WIDTH'(MENT_WIDTH + 1)) ? '0 : (mant_s_q >> shift_q);
            end
            ST_ADD: begin
                sum_d = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                              : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
            end
            ST_NRM: begin
                ovf_d = 1'b0;
                inv_d = 1'b0;
                if (op_inv) begin
                    res_d = QNAN;
                    inv_d = 1'b1;
                end else if (sum_q == '0) begin
                    res_d = '0;
                end else if (exp_n >= $signed({2'b00, EXP_MAX})) begin
                    res_d = {sign_q, EXP_MAX, {MENT_WIDTH{1'b0}}};
                    ovf_d = 1'b1;
                end else if (exp_n[EXPO_WIDTH+1] || (exp_n == '0)) begin
                    res_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
                end else begin
                    res_d = {sign_q, exp_n[EXPO_WIDTH-1:0], mant_n};
                end
            end
            ST_DONE: begin
                if (out_ready_in) cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    // State and stage registers.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            shift_q  <= '0;
            mant_l_q <= '0;
            mant_s_q <= '0;
            sum_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            shift_q  <= shift_d;
            mant_l_q <= mant_l_d;
            mant_s_q <= mant_s_d;
            sum_q    <= sum_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready_out  = (state_q == ST_IDLE);
    assign busy_out      = (state_q != ST_IDLE);
    assign out_valid_out = (state_q == ST_DONE);
    assign result_out    = res_q;
    assign overflow_out  = ovf_q;
    assign invalid_out   = inv_q;
    assign op_count_out  = cnt_q;

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle controller and datapath wrapper for single-precision floating-point addition.
- Accepts an operand pair over a valid/ready handshake and steps it through four registered phases: exponent compare, mantissa align, mantissa add/subtract, normalize/pack.
- Returns the result over a second valid/ready handshake.
- Sits between the top-level operand source and the result consumer. It is the block that sequences the adder stages and holds intermediate state between them.

Parameters:
- DATA_WIDTH, 32, total float width.
- MENT_WIDTH, 23, stored mantissa width (hidden bit excluded).
- EXPO_WIDTH, 8, exponent width.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rstn_in  input  1  reset, asynchronous, active-low.
- in_valid_in  input  1  operand pair valid.
- in_ready_out  output  1  block can accept an operand pair.
- floating1_in  input  DATA_WIDTH  operand A.
- floating2_in  input  DATA_WIDTH  operand B.
- out_valid_out  output  1  result valid.
- out_ready_in  input  1  consumer accepts the result.
- result_out  output  DATA_WIDTH  sum.
- overflow_out  output  1  result saturated to infinity; qualified by out_valid_out.
- invalid_out  output  1  an operand had exponent all-ones; qualified by out_valid_out.
- busy_out  output  1  high in every state except IDLE.
- op_count_out  output  CNT_WIDTH  number of results handed off.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs are 0 except in_ready_out, which is 1.
  - All internal registers are cleared.
- States: IDLE, CMP, ALN, ADD, NRM, DONE.
- IDLE:
  - in_ready_out=1.
  - On in_valid_in && in_ready_out: latch both operands, go to CMP.
  - in_ready_out is 0 in all other states.
- CMP:
  - exp_diff = {1'b0,expA} - {1'b0,expB}, EXPO_WIDTH+1 bits; MSB=1 means B is larger.
  - Larger operand selection: larger exponent wins; on equal exponents, mantA > mantB picks A, otherwise B.
  - Result sign = sign of the larger operand.
  - Register the large/small mantissas (hidden bit prepended; hidden bit is 0 when the exponent is 0), the larger exponent, the shift magnitude, and the operation (subtract when the signs differ).
  - Go to ALN.
- ALN:
  - Right-shift the small mantissa by the shift magnitude.
  - A shift of 24 or more yields 0.
  - Go to ADD.
- ADD:
  - 25-bit sum for same signs; large minus small for differing signs (never negative).
  - Go to NRM.
- NRM:
  - Sum bit 24 set: shift right 1, exponent +1.
  - Otherwise: locate the leading one (priority encoder), shift left by 24-position-1, subtract the same amount from the exponent.
  - Sum == 0: result +0 (0x00000000).
  - Exponent reaching 255: result {sign,8'hFF,23'd0}, overflow_out=1.
  - Exponent reaching 0 or below: result {sign,31'd0} (flush).
  - Either operand with exponent 255: result 0x7FC00000, invalid_out=1; this overrides all other results.
  - Truncation only, no rounding.
  - Go to DONE.
- DONE:
  - out_valid_out=1; result_out and flags stay stable while out_ready_in=0.
  - On out_ready_in: op_count_out increments (wraps at 2^CNT_WIDTH), go to IDLE.
  - out_valid_out drops the next cycle.
- Latency and throughput:
  - Accept edge E0 gives out_valid_out high after E4.
  - With out_ready_in held high, the minimum spacing between accepts is 6 cycles.
- In-flight protection: in_valid_in and operand changes while busy are ignored; the latched operands are used.
- Reset mid-operation: the operation is discarded, no result is produced, and op_count_out clears.

Decomposition:
- Shared package fp_add_pkg holds:
  - the state enum;
  - the hidden-bit, EXP_MAX (255) and QNAN (0x7FC00000) constants;
  - the field-extract helpers (sign, exponent, mantissa).
- One sub-module, fp_lead_one_detect: combinational 25-bit leading-one position encoder used in NRM.
- The FSM and stage registers stay in fp_add_sequencer.

Test Plan:
1. 0x3F800000 + 0x3F800000 -> result 0x40000000; out_valid after 4 edges; op_count 1.
2. 0x40400000 + 0xBF800000 (3.0 + -1.0) -> 0x40000000. Then 0x3FC00000 + 0xBFC00000 -> 0x00000000.
3. 0x4B800000 + 0x3F800000 (shift 24) -> 0x4B800000. Then 0x3F800000 + 0xC0000000 -> 0xBF800000 (sign from the larger exponent).
4. 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow=1. Then 0x7F800000 + 0x3F800000 -> 0x7FC00000, invalid=1.
5. Hold out_ready_in=0 for 10 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored. Release -> exactly one handoff, IDLE next cycle.
6. Deassert rstn_in during ALN -> immediate IDLE, outputs 0, in_ready=1, op_count 0, and no out_valid afterwards.
